sa_result_drain: RTL and testbench

- Output stage directly downstream of SA_CORE.
- Consumes the per-row 32-bit accumulator results (routport) and per-row valid bits (rvalidport), and generates the core's outread acknowledge.
- Buffers whole result vectors and serialises only the valid rows onto a single 32-bit valid/ready stream, for writeback or host readout.

---
 rtl/sa_result_drain.sv | 156 +++++++++++++++
 tb/tb_sa_result_drain.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sa_result_drain.sv
// Result drain for SA_CORE: buffers whole result vectors and serialises valid rows onto a valid/ready stream.
// Optional core stall counter built only when SA_DRAIN_STALLCNT_EN is defined.
module sa_result_drain #(
  parameter int unsigned ROWS   = 8,
  parameter int unsigned VDEPTH = 2,
  parameter int unsigned RIDX_W = 3
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [31:0]                  core_rout [0:ROWS-1],
  input  logic [0:ROWS-1]              core_rvalid,
  output logic                         core_outread,
  output logic [31:0]                  m_data,
  output logic [RIDX_W-1:0]            m_row,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic                         m_last,
  output logic [$clog2(VDEPTH+1)-1:0]  level,
  output logic [15:0]                  stall_cnt
);

  localparam int unsigned LVL_W = $clog2(VDEPTH + 1);
  localparam int unsigned PTR_W = (VDEPTH > 1) ? $clog2(VDEPTH) : 1;

  typedef enum logic {IDLE, DRAIN} state_e;

  logic [31:0]       ram_q [VDEPTH][ROWS];
  logic [ROWS-1:0]   msk_q [VDEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [ROWS-1:0]   rem_q, rem_d, in_mask, sel_oh;
  logic [RIDX_W-1:0] sel_row;
  logic [31:0]       sel_data;
  logic              sel_found, single, full, push, pop;
  state_e            state_q, state_d;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(VDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    in_mask = '0;
    for (int unsigned r = 0; r < ROWS; r++) in_mask[r] = core_rvalid[r];
  end

  assign full         = (level_q == LVL_W'(VDEPTH));
  assign core_outread = (|core_rvalid) && !full;
  assign push         = core_outread;
  assign level        = level_q;

  // Slot storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int unsigned r = 0; r < ROWS; r++) ram_q[tail_q][r] <= core_rout[r];
      msk_q[tail_q] <= in_mask;
    end
  end

  always_comb begin
    sel_oh    = '0;
    sel_row   = '0;
    sel_data  = '0;
    sel_found = 1'b0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (!sel_found && rem_q[r]) begin
        sel_found  = 1'b1;
        sel_oh[r]  = 1'b1;
        sel_row    = RIDX_W'(r);
        sel_data   = ram_q[head_q][r];
      end
    end
  end

  assign single = (rem_q != '0) && ((rem_q & (rem_q - ROWS'(1))) == '0);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    pop     = 1'b0;
    m_valid = 1'b0;
    m_last  = 1'b0;
    m_row   = '0;
    m_data  = '0;
    case (state_q)
      IDLE: begin
        if (level_q != '0) begin
          rem_d   = msk_q[head_q];
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        m_valid = 1'b1;
        m_row   = sel_row;
        m_data  = sel_data;
        m_last  = single;
        if (m_ready) begin
          rem_d = rem_q & ~sel_oh;
          if (single) begin
            pop = 1'b1;
            // With one vector left, the next head is the slot being written this cycle.
            if (level_q != LVL_W'(1))
              rem_d = msk_q[next_ptr(head_q)];
            else if (push)
              rem_d = in_mask;
            else
              state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    head_d  = pop  ? next_ptr(head_q) : head_q;
    tail_d  = push ? next_ptr(tail_q) : tail_q;
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      rem_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      level_q <= level_d;
    end
  end

`ifdef SA_DRAIN_STALLCNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      stall_q <= '0;
    else if ((|core_rvalid) && full && (stall_q != '1))
      stall_q <= stall_q + 16'd1;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_sa_result_drain.sv
// Directed self-checking bench for sa_result_drain (ROWS=8, VDEPTH=2).
module tb_sa_result_drain;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] core_rout [0:7];
  logic [0:7]  core_rvalid;
  logic        core_outread;
  logic [31:0] m_data;
  logic [2:0]  m_row;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic [1:0]  level;
  logic [15:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef SA_DRAIN_STALLCNT_EN
  localparam bit STALL_ON = 1'b1;
`else
  localparam bit STALL_ON = 1'b0;
`endif

  sa_result_drain #(.ROWS(8), .VDEPTH(2), .RIDX_W(3)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .core_rout    (core_rout),
    .core_rvalid  (core_rvalid),
    .core_outread (core_outread),
    .m_data       (m_data),
    .m_row        (m_row),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_last       (m_last),
    .level        (level),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_vec(input logic [0:7] v, input logic [31:0] base, input logic [31:0] step);
    for (int r = 0; r < 8; r++) core_rout[r] = base + step * r;
    core_rvalid = v;
  endtask

  task automatic check_word(input string tag, input int row, input logic [31:0] data, input bit last);
    check({tag, "_valid"}, {31'd0, m_valid}, 32'd1);
    check({tag, "_row"},   {29'd0, m_row},   row);
    check({tag, "_data"},  m_data,           data);
    check({tag, "_last"},  {31'd0, m_last},  {31'd0, last});
  endtask

  initial begin
    int srow [3];
    srow = '{0, 3, 6};
    rstn        = 1'b0;
    m_ready     = 1'b0;
    core_rvalid = '0;
    for (int r = 0; r < 8; r++) core_rout[r] = '0;

    // Reset state
    #12;
    check("rst_m_valid",  {31'd0, m_valid},      32'd0);
    check("rst_m_last",   {31'd0, m_last},       32'd0);
    check("rst_outread",  {31'd0, core_outread}, 32'd0);
    check("rst_m_row",    {29'd0, m_row},        32'd0);
    check("rst_m_data",   m_data,                32'd0);
    check("rst_level",    {30'd0, level},        32'd0);
    check("rst_stall",    {16'd0, stall_cnt},    32'd0);
    tick();
    rstn = 1'b1;

    // Single full vector
    tick();
    drive_vec(8'hFF, 32'd1, 32'd2);
    m_ready = 1'b1;
    #1;
    check("t1_outread", {31'd0, core_outread}, 32'd1);
    tick();
    core_rvalid = '0;
    #1;
    check("t1_outread_off", {31'd0, core_outread}, 32'd0);
    check("t1_level1",      {30'd0, level},        32'd1);
    check("t1_not_yet",     {31'd0, m_valid},      32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check_word("t1", i, 2 * i + 1, i == 7);
    end
    tick();
    check("t1_end_valid", {31'd0, m_valid}, 32'd0);
    check("t1_end_level", {30'd0, level},   32'd0);

    // Sparse mask: rows 0,3,6
    tick();
    drive_vec(8'b1001_0010, 32'd100, 32'd1);
    #1;
    check("t2_outread", {31'd0, core_outread}, 32'd1);
    tick();
    core_rvalid = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_word("t2", srow[i], 100 + srow[i], i == 2);
    end
    tick();
    check("t2_end_valid", {31'd0, m_valid}, 32'd0);

    // Backpressure: ready toggles each cycle
    m_ready = 1'b0;
    tick();
    drive_vec(8'hFF, 32'h200, 32'd4);
    tick();
    core_rvalid = '0;
    tick();
    for (int c = 0; c < 16; c++) begin
      m_ready = c[0];
      #1;
      check_word("t3", c / 2, 32'h200 + 4 * (c / 2), (c / 2) == 7);
      tick();
    end
    check("t3_end_valid", {31'd0, m_valid}, 32'd0);
    check("t3_end_level", {30'd0, level},   32'd0);

    // Full buffer with three vectors offered back-to-back
    m_ready = 1'b0;
    tick();
    drive_vec(8'hFF, 32'h1000, 32'd1);
    #1;
    check("t4_ack1", {31'd0, core_outread}, 32'd1);
    tick();
    drive_vec(8'h81, 32'h2000, 32'd1);
    #1;
    check("t4_ack2", {31'd0, core_outread}, 32'd1);
    tick();
    drive_vec(8'h18, 32'h3000, 32'd1);
    #1;
    check("t4_nack3",  {31'd0, core_outread}, 32'd0);
    check("t4_level2", {30'd0, level},        32'd2);
    check_word("t4_hold0", 0, 32'h1000, 1'b0);
    tick();
    tick();
    tick();
    check("t4_stall3", {16'd0, stall_cnt}, STALL_ON ? 32'd3 : 32'd0);
    check_word("t4_hold1", 0, 32'h1000, 1'b0);
    check("t4_nack3b", {31'd0, core_outread}, 32'd0);
    m_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check_word("t4_v1", k, 32'h1000 + k, k == 7);
      check("t4_v1_nack", {31'd0, core_outread}, 32'd0);
      tick();
    end
    check_word("t4_v2a", 0, 32'h2000, 1'b0);
    check("t4_ack3",    {31'd0, core_outread}, 32'd1);
    check("t4_level1",  {30'd0, level},        32'd1);
    check("t4_stall11", {16'd0, stall_cnt},    STALL_ON ? 32'd11 : 32'd0);
    tick();
    core_rvalid = '0;
    #1;
    check("t4_level2b", {30'd0, level}, 32'd2);
    check_word("t4_v2b", 7, 32'h2007, 1'b1);
    tick();
    check_word("t4_v3a", 3, 32'h3003, 1'b0);
    check("t4_level1b", {30'd0, level}, 32'd1);
    tick();
    check_word("t4_v3b", 4, 32'h3004, 1'b1);
    tick();
    check("t4_end_valid", {31'd0, m_valid},   32'd0);
    check("t4_end_level", {30'd0, level},     32'd0);
    check("t4_end_stall", {16'd0, stall_cnt}, STALL_ON ? 32'd11 : 32'd0);

    // Back-to-back drain of two buffered vectors
    m_ready = 1'b0;
    tick();
    drive_vec(8'hFF, 32'h4000, 32'd1);
    tick();
    drive_vec(8'hFF, 32'h5000, 32'd1);
    tick();
    core_rvalid = '0;
    m_ready = 1'b1;
    #1;
    check("t5_level2", {30'd0, level}, 32'd2);
    for (int w = 0; w < 16; w++) begin
      check_word("t5", w % 8, ((w < 8) ? 32'h4000 : 32'h5000) + (w % 8), (w % 8) == 7);
      tick();
    end
    check("t5_end_valid", {31'd0, m_valid}, 32'd0);
    check("t5_end_level", {30'd0, level},   32'd0);

    // Reset in the middle of a drain
    tick();
    drive_vec(8'hFF, 32'h6000, 32'd1);
    tick();
    core_rvalid = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_word("t6", i, 32'h6000 + i, 1'b0);
    end
    tick();
    check_word("t6_w4", 4, 32'h6004, 1'b0);
    rstn = 1'b0;
    #1;
    check("t6_rst_valid", {31'd0, m_valid},   32'd0);
    check("t6_rst_level", {30'd0, level},     32'd0);
    check("t6_rst_last",  {31'd0, m_last},    32'd0);
    check("t6_rst_stall", {16'd0, stall_cnt}, 32'd0);
    tick();
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t6_no_residue", {31'd0, m_valid}, 32'd0);
    end
    check("t6_end_level", {30'd0, level}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
